// File: rtl/weight_comp_cell_pkg.sv
// Shared definitions for the weight compute cell: result-bus layout and default weight width.
package weight_comp_cell_pkg;

   localparam int unsigned DEFAULT_WEIGHT_WIDTH = 8;

   // Result bus is {valid, data}: one flag bit sits directly above the data field.
   localparam int unsigned RESULT_BUS_EXTRA = 1;

   function automatic int unsigned result_valid_bit(input int unsigned result_width);
      return result_width;
   endfunction

endpackage

// File: rtl/offset_mac.sv
// Offset-corrected signed multiply-accumulate over the cell's weight vector.
module offset_mac
   import weight_comp_cell_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned RESULT_WIDTH  = 32,
   parameter int unsigned INDEX_WIDTH   = 18,
   parameter int unsigned WEIGHT_AMOUNT = 2,
   parameter int unsigned WEIGHT_WIDTH  = DEFAULT_WEIGHT_WIDTH,
   parameter int          WEIGHT_OFFSET = 3,
   parameter int          INPUT_OFFSET  = 2,
   parameter logic [WEIGHT_AMOUNT*WEIGHT_WIDTH-1:0] WEIGHTS = 16'h0401
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [INDEX_WIDTH-1:0]  index,
   input  logic [DATA_WIDTH-1:0]   value,
   output logic [RESULT_WIDTH-1:0] sum_c,
   output logic                    done_c
);

   localparam int unsigned AW = DATA_WIDTH + 1;
   localparam int unsigned BW = WEIGHT_WIDTH + 1;

   logic [WEIGHT_WIDTH-1:0]        weight_sel;
   logic                           in_range;
   logic signed [AW-1:0]           val_off;
   logic signed [BW-1:0]           wt_off;
   logic signed [RESULT_WIDTH-1:0] val_ext;
   logic signed [RESULT_WIDTH-1:0] wt_ext;
   logic signed [RESULT_WIDTH-1:0] product;
   logic [RESULT_WIDTH-1:0]        base;
   logic [RESULT_WIDTH-1:0]        acc;

   // Weight lookup; out-of-range indices select zero and are masked by in_range.
   always_comb begin
      weight_sel = '0;
      for (int unsigned i = 0; i < WEIGHT_AMOUNT; i++) begin
         if (index == INDEX_WIDTH'(i)) begin
            weight_sel = WEIGHTS[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      end
   end

   assign in_range = enable && (index < INDEX_WIDTH'(WEIGHT_AMOUNT));

   // Operands are sign-extended to the result width so the product wraps modulo 2^RESULT_WIDTH.
   assign val_off = $signed({1'b0, value})      - $signed(AW'(INPUT_OFFSET));
   assign wt_off  = $signed({1'b0, weight_sel}) - $signed(BW'(WEIGHT_OFFSET));
   assign val_ext = RESULT_WIDTH'(val_off);
   assign wt_ext  = RESULT_WIDTH'(wt_off);
   assign product = val_ext * wt_ext;

   assign base   = (index == '0) ? '0 : acc;
   assign sum_c  = base + $unsigned(product);
   assign done_c = in_range && (index == INDEX_WIDTH'(WEIGHT_AMOUNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (in_range) begin
         acc <= sum_c;
      end
   end

endmodule

// File: rtl/weight_comp_cell.sv
// Systolic weight cell: forwards the activation stream and inserts its completed dot product into the result chain.
module weight_comp_cell
   import weight_comp_cell_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned RESULT_WIDTH  = 32,
   parameter int unsigned INDEX_WIDTH   = 18,
   parameter int unsigned WEIGHT_AMOUNT = 2,
   parameter int unsigned WEIGHT_WIDTH  = DEFAULT_WEIGHT_WIDTH,
   parameter int          WEIGHT_OFFSET = 3,
   parameter int          INPUT_OFFSET  = 2,
   parameter logic [WEIGHT_AMOUNT*WEIGHT_WIDTH-1:0] WEIGHTS = 16'h0401
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INDEX_WIDTH-1:0]  input_index,
   input  logic [DATA_WIDTH-1:0]   input_value,
   input  logic [RESULT_WIDTH:0]   input_result,
   input  logic                    input_enable,
   output logic [INDEX_WIDTH-1:0]  output_index,
   output logic [DATA_WIDTH-1:0]   output_value,
   output logic [RESULT_WIDTH:0]   output_result,
   output logic                    output_enable
);

   localparam int unsigned VALID_BIT = result_valid_bit(RESULT_WIDTH);
   localparam int unsigned BUS_W     = RESULT_WIDTH + RESULT_BUS_EXTRA;

   logic [RESULT_WIDTH-1:0] sum_c;
   logic                    done_c;
   logic [RESULT_WIDTH-1:0] pend_data;
   logic                    pend_full;
   logic [RESULT_WIDTH-1:0] pend_data_next;
   logic                    pend_full_next;
   logic [BUS_W-1:0]        result_next;

   offset_mac #(
      .DATA_WIDTH    (DATA_WIDTH),
      .RESULT_WIDTH  (RESULT_WIDTH),
      .INDEX_WIDTH   (INDEX_WIDTH),
      .WEIGHT_AMOUNT (WEIGHT_AMOUNT),
      .WEIGHT_WIDTH  (WEIGHT_WIDTH),
      .WEIGHT_OFFSET (WEIGHT_OFFSET),
      .INPUT_OFFSET  (INPUT_OFFSET),
      .WEIGHTS       (WEIGHTS)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (input_enable),
      .index  (input_index),
      .value  (input_value),
      .sum_c  (sum_c),
      .done_c (done_c)
   );

   // Slot arbitration: upstream results first, then the pending entry, then a fresh result.
   always_comb begin
      result_next    = input_result;
      pend_data_next = pend_data;
      pend_full_next = pend_full;
      if (input_result[VALID_BIT]) begin
         if (done_c && !pend_full) begin
            pend_data_next = sum_c;
            pend_full_next = 1'b1;
         end
      end else if (pend_full) begin
         result_next    = {1'b1, pend_data};
         pend_full_next = 1'b0;
         if (done_c) begin
            pend_data_next = sum_c;
            pend_full_next = 1'b1;
         end
      end else if (done_c) begin
         result_next = {1'b1, sum_c};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_index  <= '0;
         output_value  <= '0;
         output_enable <= 1'b0;
         output_result <= '0;
         pend_data     <= '0;
         pend_full     <= 1'b0;
      end else begin
         output_index  <= input_index;
         output_value  <= input_value;
         output_enable <= input_enable;
         output_result <= result_next;
         pend_data     <= pend_data_next;
         pend_full     <= pend_full_next;
      end
   end

endmodule

// File: tb/tb_weight_comp_cell.sv
// Scoreboard bench for weight_comp_cell at default parameters.
module tb_weight_comp_cell;

   localparam int unsigned WA         = 2;
   localparam logic [15:0] WEIGHTS_TB = 16'h0401;

   typedef struct {
      logic [32:0] res;
      logic [17:0] idx;
      logic [15:0] val;
      logic        en;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [17:0] input_index;
   logic [15:0] input_value;
   logic [32:0] input_result;
   logic        input_enable;
   logic [17:0] output_index;
   logic [15:0] output_value;
   logic [32:0] output_result;
   logic        output_enable;

   int errors = 0;
   int checks = 0;
   exp_t sb[$];

   logic [31:0] m_acc  = '0;
   logic [31:0] m_pend = '0;
   bit          m_full = 1'b0;

   weight_comp_cell dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .input_index   (input_index),
      .input_value   (input_value),
      .input_result  (input_result),
      .input_enable  (input_enable),
      .output_index  (output_index),
      .output_value  (output_value),
      .output_result (output_result),
      .output_enable (output_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] prod(input int idx, input int val);
      int w;
      w = int'((WEIGHTS_TB >> (8 * idx)) & 16'hff);
      return 32'((val - 2) * (w - 3));
   endfunction

   task automatic model_reset();
      m_acc  = '0;
      m_pend = '0;
      m_full = 1'b0;
   endtask

   // Reference behaviour of one clock: accumulate, then resolve the result slot by priority.
   task automatic model_step(input logic en, input int idx, input int val,
                             input logic rv, input logic [31:0] rd);
      logic [31:0] s;
      bit d;
      exp_t e;
      s = '0;
      d = 1'b0;
      if (en && idx < int'(WA)) begin
         s     = ((idx == 0) ? 32'd0 : m_acc) + prod(idx, val);
         m_acc = s;
         d     = (idx == int'(WA) - 1);
      end
      e.idx = 18'(idx);
      e.val = 16'(val);
      e.en  = en;
      if (rv) begin
         e.res = {rv, rd};
         if (d && !m_full) begin
            m_pend = s;
            m_full = 1'b1;
         end
      end else if (m_full) begin
         e.res  = {1'b1, m_pend};
         m_full = 1'b0;
         if (d) begin
            m_pend = s;
            m_full = 1'b1;
         end
      end else if (d) begin
         e.res = {1'b1, s};
      end else begin
         e.res = {1'b0, rd};
      end
      sb.push_back(e);
   endtask

   task automatic drive(input logic en, input int idx, input int val,
                        input logic rv, input logic [31:0] rd);
      exp_t e;
      input_enable = en;
      input_index  = 18'(idx);
      input_value  = 16'(val);
      input_result = {rv, rd};
      model_step(en, idx, val, rv, rd);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk("res", 64'(output_result), 64'(e.res));
         chk("idx", 64'(output_index),  64'(e.idx));
         chk("val", 64'(output_value),  64'(e.val));
         chk("en",  64'(output_enable), 64'(e.en));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      input_index  = '0;
      input_value  = '0;
      input_result = '0;
      input_enable = 1'b0;
      #7;
      chk("rst_res", 64'(output_result), 64'd0);
      chk("rst_idx", 64'(output_index),  64'd0);
      chk("rst_val", 64'(output_value),  64'd0);
      chk("rst_en",  64'(output_enable), 64'd0);
      rst_n = 1'b1;

      // Basic two-step dot product: (0-2)*(1-3) + (4-2)*(4-3) = 6
      drive(1'b1, 0, 0, 1'b0, 32'd0);
      chk("r033a", 64'(output_result), 64'h0);
      drive(1'b1, 1, 4, 1'b0, 32'd0);
      chk("r033b", 64'(output_result), 64'h1_0000_0006);

      // Occupied slots push the completed -2 into pending
      drive(1'b1, 0, 5, 1'b1, 32'd6);
      chk("r034a", 64'(output_result), 64'h1_0000_0006);
      drive(1'b1, 1, 6, 1'b1, 32'd55);
      chk("r034b", 64'(output_result), 64'h1_0000_0037);

      drive(1'b0, 0, 0, 1'b1, 32'd45);
      chk("r035a", 64'(output_result), 64'h1_0000_002d);
      drive(1'b0, 0, 0, 1'b0, 32'd100);
      chk("r035b", 64'(output_result), 64'h1_ffff_fffe);

      // Out-of-range index leaves the accumulator alone
      drive(1'b1, 0, 0, 1'b0, 32'd0);
      drive(1'b1, 5, 9, 1'b0, 32'd0);
      chk("r036_idx", 64'(output_index), 64'd5);
      drive(1'b1, 1, 4, 1'b0, 32'd0);
      chk("r036_res", 64'(output_result), 64'h1_0000_0006);

      // Reset mid-vector
      drive(1'b1, 0, 3, 1'b1, 32'd77);
      rst_n = 1'b0;
      #2;
      chk("r037_res", 64'(output_result), 64'd0);
      chk("r037_idx", 64'(output_index),  64'd0);
      chk("r037_val", 64'(output_value),  64'd0);
      chk("r037_en",  64'(output_enable), 64'd0);
      model_reset();
      rst_n = 1'b1;
      drive(1'b1, 0, 4, 1'b0, 32'd0);
      drive(1'b1, 1, 4, 1'b0, 32'd0);
      chk("r037_after", 64'(output_result), 64'h1_ffff_fffe);

      // Two completions under busy slots: first kept, second dropped
      drive(1'b1, 0, 0, 1'b1, 32'd11);
      drive(1'b1, 1, 4, 1'b1, 32'd12);
      drive(1'b1, 0, 2, 1'b1, 32'd13);
      drive(1'b1, 1, 10, 1'b1, 32'd14);
      drive(1'b0, 0, 0, 1'b0, 32'd7);
      chk("r038_first", 64'(output_result), 64'h1_0000_0006);
      drive(1'b0, 0, 0, 1'b0, 32'd9);
      chk("r038_drop", 64'(output_result), 64'h0_0000_0009);

      // Random traffic against the reference model
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 65535)), 1'($urandom_range(0, 2) == 0), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weight_comp_cell.md
WEIGHT_COMP_CELL -- requirements
Module: weight_comp_cell

Interface
- REQ-001: Parameter DATA_WIDTH, default 16: width of the input value.
- REQ-002: Parameter RESULT_WIDTH, default 32: width of the result data field.
- REQ-003: Parameter INDEX_WIDTH, default 18: width of the index.
- REQ-004: Parameter WEIGHT_AMOUNT, default 2: number of weights held by the cell.
- REQ-005: Parameter WEIGHT_WIDTH, default 8: width of each weight.
- REQ-006: Parameter WEIGHT_OFFSET, default 3: zero-point subtracted from each weight.
- REQ-007: Parameter INPUT_OFFSET, default 2: zero-point subtracted from each input value.
- REQ-008: Parameter WEIGHTS, default 16'h0401: packed unsigned weights; weight[i] = bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- REQ-009: One clock; reset is asynchronous and active-low.
- REQ-010: clk  in  1  rising-edge clock.
- REQ-011: rst_n  in  1  asynchronous active-low reset.
- REQ-012: input_index  in  INDEX_WIDTH  position of input_value within the current vector.
- REQ-013: input_value  in  DATA_WIDTH  unsigned activation.
- REQ-014: input_result  in  RESULT_WIDTH+1  MSB = valid flag, low bits = two's-complement result from the upstream cell.
- REQ-015: input_enable  in  1  input_index/input_value are valid this cycle.
- REQ-016: output_index, output_value, output_enable  out  as inputs  registered copies of the inputs, forwarded downstream.
- REQ-017: output_result  out  RESULT_WIDTH+1  registered result slot, same layout as input_result.

Function
- REQ-018: All outputs SHALL be registered, with 1-cycle latency from the inputs.
- REQ-019: output_index, output_value and output_enable SHALL equal the previous-cycle input_index, input_value and input_enable, unconditionally.
- REQ-020: When input_enable=1 and input_index < WEIGHT_AMOUNT, product = (input_value - INPUT_OFFSET) * (weight[input_index] - WEIGHT_OFFSET), computed signed and truncated to RESULT_WIDTH.
- REQ-021: Index 0 SHALL start a new accumulation (acc = product); other in-range indices SHALL add (acc += product).
- REQ-022: At index WEIGHT_AMOUNT-1 the cell's result SHALL be complete (acc + product); the accumulator SHALL be reused afterwards.
- REQ-023: An index >= WEIGHT_AMOUNT, or input_enable=0, SHALL leave the accumulator unchanged.
- REQ-024: Result slot priority, each cycle:
  - (a) input_result valid: forward input_result unchanged;
  - (b) otherwise, pending buffer full: emit {1, pending} and free the buffer;
  - (c) otherwise, result completing this cycle: emit {1, result};
  - (d) otherwise: forward input_result unchanged (valid 0).
- REQ-025: A completed result not emitted in the same cycle SHALL go to a one-entry pending buffer.
- REQ-026: If the buffer is still occupied after this cycle's emission, the newly completed result SHALL be discarded; upstream guarantees spacing.
- REQ-027: Slot forwarding and pending emission SHALL operate regardless of input_enable.
- REQ-028: Arithmetic SHALL wrap modulo 2^RESULT_WIDTH; no saturation.

Reset
- REQ-029: rst_n low SHALL asynchronously clear all outputs, the accumulator and the pending buffer (including its full flag) to 0.
- REQ-030: A partial accumulation interrupted by reset SHALL be lost; after release, the first index-0 input starts cleanly.

Structure
- REQ-031: A shared package SHALL hold the result-bus layout constant (valid bit at RESULT_WIDTH) and the default WEIGHT_WIDTH.
- REQ-032: The product computation SHALL be one sub-module, offset_mac (offset subtract, signed multiply, accumulate); slot arbitration and pending logic SHALL stay in the top module.

Verification (defaults; all values decimal)
- REQ-033: Enable, idx0 val0, input_result {0,0} -> next cycle output_result {0,0}; then idx1 val4 -> {1,6}.
- REQ-034: idx0 val5 with input_result {1,6} -> output {1,6}; then idx1 val6 with {1,55} -> output {1,55}; -2 is held pending.
- REQ-035: Enable=0, input_result {1,45} -> output {1,45}; then input_result {0,100} -> output {1,0xFFFFFFFE}.
- REQ-036: Index 5 with enable=1 -> accumulator untouched; output_index=5 next cycle.
- REQ-037: Assert rst_n low mid-vector (after idx0) -> all outputs 0 immediately; after release, idx0 val4 then idx1 val4 -> {1,-2}.
- REQ-038: Complete two results while input_result stays valid -> first is emitted on the first invalid slot, second is discarded.
